// File: rtl/keypad_fifo_scanner.sv
// keypad_fifo_scanner: 4x4 keypad scanner with debounce, key encoder and a small key-code FIFO.
//   clk, rst      : clock, asynchronous active-high reset
//   rowwrite[3:0] : one-hot active-low row drive
//   colread[3:0]  : active-low column sense
//   ack           : consume request, acted on at its rising edge
//   statusordata  : 1 = status word, 0 = head key code on keyout
//   keyout[15:0]  : combinational read word
module keypad_fifo_scanner #(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [3:0]  rowwrite,
  input  logic [3:0]  colread,
  input  logic        ack,
  input  logic        statusordata,
  output logic [15:0] keyout
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE_SCANS + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_N = DEPTH[AW:0];
  typedef enum logic [1:0] {IDLE, CONFIRM, HELD, RELEASE} state_t;
  logic [3:0] col_m, col_s, closed, code, code_n, cand, cand_n;
  logic [1:0] r, c, hits, hits_n;
  logic [2:0] n;
  logic [DW-1:0] dwell;
  logic last, scan_done, single;
  state_t state, state_n;
  logic [BW-1:0] cnt, cnt_n;
  logic push, pop, wr, full, ack_d, overflow;
  logic [3:0] mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0] count;
  assign rowwrite = ~(4'b1 << r);
  assign closed = ~col_s;
  assign n = 3'(closed[0]) + 3'(closed[1]) + 3'(closed[2]) + 3'(closed[3]);
  assign c = closed[0] ? 2'd0 : closed[1] ? 2'd1 : closed[2] ? 2'd2 : 2'd3;
  assign last = dwell == DW'(SCAN_DIV - 1);
  assign scan_done = last && r == 2'd3;
  // contacts seen so far this scan, saturating at 2 (ghost)
  assign hits_n = (3'(hits) + n >= 3'd2) ? 2'd2 : 2'(3'(hits) + n);
  assign code_n = n == 3'd1 ? {r, c} : code;
  assign single = hits_n == 2'd1;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      col_m <= 4'hF;
      col_s <= 4'hF;
      r <= 2'd0;
      dwell <= '0;
      hits <= 2'd0;
      code <= 4'd0;
    end else begin
      col_m <= colread;
      col_s <= col_m;
      if (last) begin
        dwell <= '0;
        r <= r + 2'd1;
        hits <= scan_done ? 2'd0 : hits_n;
        code <= code_n;
      end else dwell <= dwell + 1'b1;
    end
  always_comb begin
    state_n = state;
    cand_n = cand;
    cnt_n = cnt;
    push = 1'b0;
    if (scan_done) begin
      if (state == IDLE || state == CONFIRM) begin
        if (!single) state_n = IDLE;
        else begin
          cnt_n = (state == CONFIRM && code_n == cand) ? cnt + 1'b1 : BW'(1);
          cand_n = code_n;
          push = cnt_n == BW'(DEBOUNCE_SCANS);
          state_n = push ? HELD : CONFIRM;
        end
      end else begin
        if (single) state_n = HELD;
        else begin
          cnt_n = state == RELEASE ? cnt + 1'b1 : BW'(1);
          state_n = cnt_n == BW'(DEBOUNCE_SCANS) ? IDLE : RELEASE;
        end
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cand <= 4'd0;
      cnt <= '0;
    end else begin
      state <= state_n;
      cand <= cand_n;
      cnt <= cnt_n;
    end
  assign full = count == FULL_N;
  assign pop = ack && !ack_d && |count;
  // a pop in the same cycle frees the slot a full-FIFO push needs
  assign wr = push && (!full || pop);
  always_ff @(posedge clk)
    if (wr) mem[tail] <= code_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      ack_d <= 1'b0;
      overflow <= 1'b0;
    end else begin
      ack_d <= ack;
      if (wr) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      count <= count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
      overflow <= pop ? 1'b0 : (push && full) ? 1'b1 : overflow;
    end
  assign keyout = statusordata ? {14'b0, overflow, |count} : |count ? {12'b0, mem[head]} : 16'h0000;
endmodule

// File: doc/keypad_fifo_scanner.md
# keypad_fifo_scanner

Device-side responder for the CPU's keypad port: scans a 4x4 matrix keypad, debounces and encodes key presses, and queues codes in a small FIFO. The address decoder reads it through the status/data/ack protocol: `statusordata=1` selects the status word, `statusordata=0` selects the head key code, and `ack` consumes one entry. It sits between the keypad pins and the memory-mapped input multiplexer (status at KEYPAD+1, data at KEYPAD).

## Interface
- SCAN_DIV, 50000: clock cycles each row is driven; minimum 4.
- DEBOUNCE_SCANS, 4: consecutive identical full scans required to accept a press or a release; minimum 1.
- DEPTH, 4: FIFO entries; power of 2, minimum 2.

- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rowwrite  out  4  row drive, one-hot active-low.
- colread  in  4  column sense, active-low (pulled up, low = key closed on the driven row).
- ack  in  1  consume request from the decoder; level, rising edge acted on.
- statusordata  in  1  1 = status view, 0 = data view on keyout.
- keyout  out  16  combinational read word.

## Operation
- colread passes through a 2-flop synchronizer before any use.
- Scanner: row index r cycles 0,1,2,3,0,…; rowwrite = ~(1<<r). Each row is held SCAN_DIV cycles. Synchronized colread is sampled on the last cycle of the dwell.
- After row 3's sample, the scan is complete. The scan result is one of:
  - single key: exactly one closed contact across all 16 positions, code = 4*r + c, where c is the index of the low column bit;
  - none: zero contacts, or two or more contacts (ghosting is rejected).
- Debounce FSM, evaluated once per completed scan:
  - IDLE: single key K → CONFIRM with cand=K, cnt=1. Otherwise stay.
  - CONFIRM: same K → cnt+1. When cnt reaches DEBOUNCE_SCANS, push K and go to HELD. A different single key restarts with cnt=1 and the new cand. None → IDLE.
  - HELD: none → RELEASE with cnt=1. Anything else → stay. There is no auto-repeat.
  - RELEASE: none → cnt+1, and at DEBOUNCE_SCANS go to IDLE. Any key → HELD.
  - With DEBOUNCE_SCANS=1, CONFIRM pushes on the first scan and RELEASE exits on the first none-scan.
- FIFO: DEPTH entries of 4 bits, with head/tail pointers and a count of width log2(DEPTH)+1.
  - A push while full is dropped and sets the sticky overflow flag.
  - A pop while empty has no effect.
  - Push and pop in the same cycle are both performed and the count is unchanged. When full, this push is accepted and overflow is not set.
- Pop happens on an ack rising edge: ack=1 while ack_d=0 (ack_d is registered ack, reset 0). A multi-cycle ack pops exactly once. A pop also clears overflow.
- keyout:
  - statusordata=1: {14'b0, overflow, not_empty}.
  - statusordata=0: {12'b0, head code} if not empty, else 16'h0000.

## Timing
- Reset values: rowwrite=4'b1110, r=0, dwell counter 0, FSM IDLE, FIFO empty, overflow=0, ack_d=0. keyout therefore reads 16'h0000 in both views.
- Reset takes effect immediately, including mid-scan, mid-debounce, or with FIFO contents. Queued keys are lost. A key still held at reset release is accepted after DEBOUNCE_SCANS scans.
- Synchronizer latency is 2 cycles, so a contact must be stable from dwell cycle SCAN_DIV-3 to be seen.
- Scan period is 4*SCAN_DIV cycles. Push latency from a stable press is at most (DEBOUNCE_SCANS+1)*4*SCAN_DIV + 2 cycles.
- A push registers on the scan-complete edge. keyout reflects it from the following cycle.
- Pop: the decoder samples keyout combinationally during the cycle ack first rises, and the head advances at the end of that cycle. The next entry is visible the cycle after.
- keyout changes only on clk edges or on a statusordata change (combinational mux).

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE_SCANS=2, DEPTH=4.
- Press row 2/col 1 (colread low on bit 1 while rowwrite=4'b1011), held 10 scans → exactly one push. Status reads 16'h0001, data reads 16'h0009. After a 1-cycle ack, status reads 16'h0000. Release, then press again → a second 16'h0009 is pushed.
- Bounce: a contact present for 1 scan, absent for 1, present for 1 → no push. A stable 2-scan press → one push. Release chatter while HELD (1 none-scan, then key) → no second push.
- Press codes 0,5,10,15,3 in sequence, each with proper release, and no reads → status 16'h0003. Reads return 0,5,10,15 in order. Status bit1 is 0 after the first ack, and status is 16'h0000 after the fourth.
- Hold ack high for 5 cycles with 2 entries queued → exactly one pop, and status stays 16'h0001. Ack on empty FIFO → no change, data reads 16'h0000.
- Two keys pressed simultaneously (cols 0 and 2 on row 1) → no push. Releasing one leaves a single key → that code is pushed after 2 scans.
- Assert rst for 1 cycle with 3 entries queued mid-scan → rowwrite=4'b1110 and keyout=16'h0000 immediately. The scan restarts at row 0.
